// File: rtl/bcrypt_core_arbiter.sv
// bcrypt_core_arbiter: sequences N cores through load/compute/store and muxes their BRAM port A.
// Optional wait watchdog is enabled by defining ARB_TIMEOUT_EN.
module bcrypt_core_arbiter #(
  parameter int          NUM_CORES      = 14,
  parameter int          DW             = 32,
  parameter int          AW             = 32,
  parameter int          IDX_W          = 8,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1048576
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           go,
  input  logic [NUM_CORES-1:0]           core_mask,
  output logic [2*NUM_CORES-1:0]         core_cmd,
  input  logic [2*NUM_CORES-1:0]         core_ack,
  input  logic [(DW/8)*NUM_CORES-1:0]    core_we,
  input  logic [AW*NUM_CORES-1:0]        core_addr,
  input  logic [DW*NUM_CORES-1:0]        core_wdata,
  output logic                           bram_clk,
  output logic                           bram_rst,
  output logic                           bram_en,
  output logic [DW/8-1:0]                bram_we,
  output logic [AW-1:0]                  bram_addr,
  output logic [DW-1:0]                  bram_wdata,
  output logic [IDX_W-1:0]               cur_core,
  output logic                           all_done,
  output logic                           timeout
);
  localparam int BW = DW / 8;
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_LOAD, COMPUTE, WAIT_COMPUTE, STORE, WAIT_STORE, DONE} state_t;
  state_t                 r_state, w_state_nx;
  logic [IDX_W-1:0]       r_idx, w_idx_nx;
  logic [NUM_CORES-1:0]   r_mask, w_mask_nx, w_sel_oh, w_ack2;
  logic [2*NUM_CORES-1:0] r_cmd, w_cmd_nx;
  logic [BW-1:0]          r_bram_we, w_we_sel;
  logic [AW-1:0]          r_bram_addr, w_addr_sel;
  logic [DW-1:0]          r_bram_wdata, w_wdata_sel;
  logic                   r_timeout, w_timeout_nx;
  logic [1:0]             w_ack_sel, w_cmd_sel;
  logic                   w_mask_sel, w_at_end, w_all_c, w_fire, w_pass;
  always_comb begin
    w_sel_oh    = '0;
    w_ack2      = '0;
    w_ack_sel   = '0;
    w_cmd_sel   = '0;
    w_mask_sel  = 1'b0;
    w_we_sel    = '0;
    w_addr_sel  = '0;
    w_wdata_sel = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_ack2[i] = core_ack[2*i +: 2] == 2'd2;
      if (r_idx == IDX_W'(i)) begin
        w_sel_oh[i] = 1'b1;
        w_ack_sel   = core_ack[2*i +: 2];
        w_cmd_sel   = r_cmd[2*i +: 2];
        w_mask_sel  = r_mask[i];
        w_we_sel    = core_we[BW*i +: BW];
        w_addr_sel  = core_addr[AW*i +: AW];
        w_wdata_sel = core_wdata[DW*i +: DW];
      end
    end
  end
  assign w_at_end = r_idx == IDX_W'(NUM_CORES);
  assign w_all_c  = &(~r_mask | w_ack2);
`ifdef ARB_TIMEOUT_EN
  logic [31:0] r_cnt;
  logic        w_wait;
  assign w_wait = r_state inside {WAIT_LOAD, WAIT_COMPUTE, WAIT_STORE};
  assign w_fire = w_wait && r_cnt == TIMEOUT_CYCLES - 32'd1;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else     r_cnt <= (w_state_nx != r_state) ? '0 : w_wait ? r_cnt + 32'd1 : r_cnt;
`else
  assign w_fire = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_mask       <= '0;
      r_cmd        <= '0;
      r_bram_we    <= '0;
      r_bram_addr  <= '0;
      r_bram_wdata <= '0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_idx        <= w_idx_nx;
      r_mask       <= w_mask_nx;
      r_cmd        <= w_cmd_nx;
      r_bram_we    <= w_pass ? w_we_sel : '0;
      r_bram_addr  <= w_pass ? w_addr_sel : r_bram_addr;
      r_bram_wdata <= w_pass ? w_wdata_sel : r_bram_wdata;
      r_timeout    <= w_timeout_nx;
    end
  end
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:         w_state_nx = go ? LOAD : IDLE;
      LOAD:         w_state_nx = w_at_end ? COMPUTE : w_mask_sel ? WAIT_LOAD : LOAD;
      WAIT_LOAD:    w_state_nx = w_ack_sel == 2'd1 ? LOAD : WAIT_LOAD;
      COMPUTE:      w_state_nx = WAIT_COMPUTE;
      WAIT_COMPUTE: w_state_nx = w_all_c ? STORE : WAIT_COMPUTE;
      STORE:        w_state_nx = w_at_end ? DONE : w_mask_sel ? WAIT_STORE : STORE;
      WAIT_STORE:   w_state_nx = w_ack_sel == 2'd3 ? STORE : WAIT_STORE;
      default:      w_state_nx = DONE;
    endcase
    if (w_fire) w_state_nx = DONE;
    if (!go) w_state_nx = IDLE;
  end
  always_comb begin
    w_idx_nx     = r_idx;
    w_cmd_nx     = r_cmd;
    w_mask_nx    = r_mask;
    w_timeout_nx = r_timeout | w_fire;
    case (r_state)
      IDLE: begin
        w_idx_nx  = '0;
        w_cmd_nx  = '0;
        w_mask_nx = go ? core_mask : r_mask;
      end
      LOAD, STORE: begin
        if (w_at_end) w_idx_nx = r_state == LOAD ? '0 : r_idx;
        else if (!w_mask_sel) w_idx_nx = r_idx + 1'b1;
        for (int i = 0; i < NUM_CORES; i++)
          if (w_sel_oh[i] && r_mask[i]) w_cmd_nx[2*i +: 2] = r_state == LOAD ? 2'd1 : 2'd3;
      end
      WAIT_LOAD: w_idx_nx = w_ack_sel == 2'd1 ? r_idx + 1'b1 : r_idx;
      COMPUTE:
        for (int i = 0; i < NUM_CORES; i++)
          if (r_mask[i]) w_cmd_nx[2*i +: 2] = 2'd2;
      WAIT_COMPUTE: w_idx_nx = w_all_c ? '0 : r_idx;
      WAIT_STORE: if (w_ack_sel == 2'd3) begin
        w_idx_nx = r_idx + 1'b1;
        for (int i = 0; i < NUM_CORES; i++)
          if (w_sel_oh[i]) w_cmd_nx[2*i +: 2] = 2'd0;
      end
      default: ;
    endcase
    if (w_fire) w_cmd_nx = '0;
    if (!go) begin
      w_idx_nx     = '0;
      w_cmd_nx     = '0;
      w_timeout_nx = 1'b0;
    end
  end
  // Only the core currently being served, while it holds load/store, may reach the BRAM.
  assign w_pass = go && !w_fire &&
                  ((r_state == WAIT_LOAD && w_cmd_sel == 2'd1) || (r_state == WAIT_STORE && w_cmd_sel == 2'd3));
  assign core_cmd   = r_cmd;
  assign bram_clk   = clk;
  assign bram_rst   = 1'b0;
  assign bram_en    = 1'b1;
  assign bram_we    = r_bram_we;
  assign bram_addr  = r_bram_addr;
  assign bram_wdata = r_bram_wdata;
  assign cur_core   = r_idx;
  assign all_done   = r_state == DONE;
  assign timeout    = r_timeout;
endmodule
